um245r_bridge: RTL and testbench

- Bridges the CPU's byte-wide UART target/source device to an external UM245R USB parallel FIFO.
- Downstream of the CPU:
  - CPU writes (target device `uart`) are buffered into a TX queue.
  - TX bytes are drained to the UM245R using its WR/_TXE handshake.
  - Bytes arriving on the UM245R are pulled via _RD/_RXF into an RX queue, which the CPU reads as a B-bus source.
- Supplies the _flag_do / _flag_di status bits consumed by the CPU flags register.

---
 rtl/um245r_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_um245r_bridge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/um245r_bridge.sv
// Bridge between the CPU's byte-wide UART device and a UM245R USB parallel FIFO.
// Holds a TX queue drained over WR/_TXE and an RX queue filled over _RD/_RXF, one strobe at a time.
module um245r_bridge #(
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  parameter int WR_PULSE   = 3,
  parameter int RD_PULSE   = 3,
  parameter int PRECHARGE  = 2
) (
  input  logic       clk,
  input  logic       _mr,
  input  logic       _uart_in,
  input  logic [7:0] data_in,
  input  logic       _uart_pop,
  output logic [7:0] data_out,
  output logic       _flag_do,
  output logic       _flag_di,
  input  logic       _txe,
  input  logic       _rxf,
  output logic       usb_wr,
  output logic       _usb_rd,
  output logic [7:0] usb_d_out,
  output logic       usb_d_oe,
  input  logic [7:0] usb_d_in,
  output logic       overrun
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  localparam logic [TCW-1:0] TX_FULL  = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL  = RCW'(RX_DEPTH);
  localparam logic [3:0]     WR_LAST  = 4'(WR_PULSE - 2);
  localparam logic [3:0]     WR_DONE  = 4'(WR_PULSE - 1);
  localparam logic [3:0]     RD_LAST  = 4'(RD_PULSE - 2);
  localparam logic [3:0]     PRE_MIN  = 4'(PRECHARGE - 1);
  localparam logic [3:0]     PRE_TOUT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETUP, S_WR_HOLD, S_RD_ASSERT, S_RD_SAMPLE, S_PRE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           pre_rd_q, pre_rd_d;
  logic           wr_q, wr_d, rd_n_q, rd_n_d, oe_q, oe_d;
  logic [7:0]     dout_q, dout_d;
  logic [1:0]     txe_sync_q, rxf_sync_q;
  logic           txe_s, rxf_s;

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           tx_push, tx_pop, rx_push, rx_pop, rx_push_req;
  logic           flag_do_q, flag_do_d, flag_di_q, flag_di_d, overrun_q, overrun_d;
  logic           rx_ready, tx_ready;

  assign txe_s = txe_sync_q[1];
  assign rxf_s = rxf_sync_q[1];

  // Queue bookkeeping: pops act on the old head, and "full" is judged after a same-edge pop.
  always_comb begin
    tx_push   = !_uart_in && ((tx_cnt_q != TX_FULL) || tx_pop);
    tx_wp_d   = tx_push ? tx_wp_q + TAW'(1) : tx_wp_q;
    tx_rp_d   = tx_pop  ? tx_rp_q + TAW'(1) : tx_rp_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TCW'(1);
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TCW'(1);
    overrun_d = overrun_q | (!_uart_in && !tx_push);
    flag_do_d = (tx_cnt_d == TX_FULL);

    rx_pop    = !_uart_pop && (rx_cnt_q != '0);
    rx_push   = rx_push_req && ((rx_cnt_q != RX_FULL) || rx_pop);
    rx_wp_d   = rx_push ? rx_wp_q + RAW'(1) : rx_wp_q;
    rx_rp_d   = rx_pop  ? rx_rp_q + RAW'(1) : rx_rp_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RCW'(1);
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RCW'(1);
    flag_di_d = (rx_cnt_d == '0);
  end

  assign rx_ready = !rxf_s && (rx_cnt_q != RX_FULL);
  assign tx_ready = !txe_s && (tx_cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_rd_d    = pre_rd_q;
    wr_d        = wr_q;
    rd_n_d      = rd_n_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          state_d = S_RD_ASSERT;
          rd_n_d  = 1'b0;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end else if (tx_ready) begin
          state_d = S_WR_SETUP;
          dout_d  = tx_mem_q[tx_rp_q];
          oe_d    = 1'b1;
          wr_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_HOLD;
        cnt_d   = '0;
      end
      S_WR_HOLD: begin
        // WR falls on the WR_LAST edge; the data stays driven for one more cycle.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WR_LAST) begin
          wr_d   = 1'b0;
          tx_pop = 1'b1;
        end else if (cnt_q == WR_DONE) begin
          oe_d     = 1'b0;
          state_d  = S_PRE;
          cnt_d    = '0;
          pre_rd_d = 1'b0;
        end
      end
      S_RD_ASSERT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == RD_LAST) state_d = S_RD_SAMPLE;
      end
      S_RD_SAMPLE: begin
        rx_push_req = 1'b1;
        rd_n_d      = 1'b1;
        state_d     = S_PRE;
        cnt_d       = '0;
        pre_rd_d    = 1'b1;
      end
      S_PRE: begin
        if (((cnt_q >= PRE_MIN) && (pre_rd_q ? rxf_s : txe_s)) || (cnt_q == PRE_TOUT)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pre_rd_q   <= 1'b0;
      wr_q       <= 1'b0;
      rd_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      txe_sync_q <= 2'b11;
      rxf_sync_q <= 2'b11;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      flag_do_q  <= 1'b0;
      flag_di_q  <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_rd_q   <= pre_rd_d;
      wr_q       <= wr_d;
      rd_n_q     <= rd_n_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      txe_sync_q <= {txe_sync_q[0], _txe};
      rxf_sync_q <= {rxf_sync_q[0], _rxf};
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      flag_do_q  <= flag_do_d;
      flag_di_q  <= flag_di_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage needs no reset: the occupancy counters decide what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= data_in;
    if (rx_push) rx_mem_q[rx_wp_q] <= usb_d_in;
  end

  assign data_out  = (rx_cnt_q == '0) ? 8'h00 : rx_mem_q[rx_rp_q];
  assign _flag_do  = flag_do_q;
  assign _flag_di  = flag_di_q;
  assign overrun   = overrun_q;
  assign usb_wr    = wr_q;
  assign _usb_rd   = rd_n_q;
  assign usb_d_oe  = oe_q;
  assign usb_d_out = dout_q;

endmodule

// File: tb/tb_um245r_bridge.sv
// Bench for um245r_bridge: directed CPU/UM245R traffic, a queue-level model with a
// per-cycle compare process, and literal expectations for each scenario.
module tb_um245r_bridge;

  localparam int DEPTH    = 4;
  localparam int WR_PULSE = 3;
  localparam int RD_PULSE = 3;

  logic       clk = 1'b0;
  logic       _mr, _uart_in, _uart_pop, _txe, _rxf;
  logic [7:0] data_in, usb_d_in;
  logic [7:0] data_out, usb_d_out;
  logic       _flag_do, _flag_di, usb_wr, _usb_rd, usb_d_oe, overrun;

  um245r_bridge dut (
    .clk(clk), ._mr(_mr), ._uart_in(_uart_in), .data_in(data_in), ._uart_pop(_uart_pop),
    .data_out(data_out), ._flag_do(_flag_do), ._flag_di(_flag_di), ._txe(_txe), ._rxf(_rxf),
    .usb_wr(usb_wr), ._usb_rd(_usb_rd), .usb_d_out(usb_d_out), .usb_d_oe(usb_d_oe),
    .usb_d_in(usb_d_in), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: expected queue contents, sticky overrun, bytes seen by the USB device.
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  logic [7:0] got_q[$];
  logic       ovr_m = 1'b0;
  int         rd_strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Compare process: samples inputs at the edge, outputs 1 time unit later.
  initial begin
    logic       prev_wr, prev_rd_n, s_uart_in, s_pop, rd_push;
    logic [7:0] prev_dout, s_din, s_usb_din, exp_do;
    int         wr_len, rd_len;
    prev_wr = 1'b0; prev_rd_n = 1'b1; prev_dout = '0; wr_len = 0; rd_len = 0;
    forever begin
      @(posedge clk);
      s_uart_in = _uart_in; s_din = data_in; s_pop = _uart_pop; s_usb_din = usb_d_in;
      #1;
      if (!_mr) begin
        tx_m.delete(); rx_m.delete(); ovr_m = 1'b0;
        prev_wr = 1'b0; prev_rd_n = 1'b1; wr_len = 0; rd_len = 0;
      end else begin
        rd_push = 1'b0;
        if (prev_wr && !usb_wr) begin
          check("wr_width", wr_len, WR_PULSE);
          check("wr_data_hold", 32'(usb_d_oe), 32'd1);
          got_q.push_back(prev_dout);
          if (tx_m.size() == 0) timeout("tx_underflow");
          else begin
            check("tx_byte", 32'(prev_dout), 32'(tx_m[0]));
            void'(tx_m.pop_front());
          end
          wr_len = 0;
        end
        if (!prev_rd_n && _usb_rd) begin
          check("rd_width", rd_len, RD_PULSE);
          rd_push = 1'b1;
          rd_strobes++;
          rd_len = 0;
        end
        if (!s_pop && rx_m.size() > 0) void'(rx_m.pop_front());
        if (rd_push) rx_m.push_back(s_usb_din);
        if (!s_uart_in) begin
          if (tx_m.size() < DEPTH) tx_m.push_back(s_din);
          else ovr_m = 1'b1;
        end
        if (usb_wr) begin
          wr_len++;
          check("wr_oe", 32'(usb_d_oe), 32'd1);
        end
        if (!_usb_rd) rd_len++;
        exp_do = (rx_m.size() > 0) ? rx_m[0] : 8'h00;
        check("one_strobe", 32'(usb_wr && !_usb_rd), 32'd0);
        check("flag_do", 32'(_flag_do), 32'(tx_m.size() == DEPTH));
        check("flag_di", 32'(_flag_di), 32'(rx_m.size() == 0));
        check("data_out", 32'(data_out), 32'(exp_do));
        check("overrun", 32'(overrun), 32'(ovr_m));
        prev_wr = usb_wr; prev_rd_n = _usb_rd; prev_dout = usb_d_out;
      end
    end
  end

  task automatic cpu_write(input logic [7:0] b);
    @(negedge clk); _uart_in = 1'b0; data_in = b;
    @(negedge clk); _uart_in = 1'b1;
  endtask

  task automatic cpu_pop();
    @(negedge clk); _uart_pop = 1'b0;
    @(negedge clk); _uart_pop = 1'b1;
  endtask

  task automatic wait_got(input int n, input int bound);
    int k = 0;
    while (got_q.size() < n && k < bound) begin @(negedge clk); k++; end
    if (got_q.size() < n) timeout("wait_tx_byte");
  endtask

  task automatic wait_rd_done(input int bound);
    int k = 0;
    while (_usb_rd && k < bound) begin @(negedge clk); k++; end
    while (!_usb_rd && k < bound) begin @(negedge clk); k++; end
    if (k >= bound) timeout("wait_rd_strobe");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, base, strobes0;
    logic ok, seen, rd_first;
    _mr = 1'b0; _uart_in = 1'b1; _uart_pop = 1'b1; data_in = '0;
    _txe = 1'b0; _rxf = 1'b1; usb_d_in = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    _mr = 1'b1;
    @(negedge clk);
    check("rst_usb_wr", 32'(usb_wr), 32'd0);
    check("rst_usb_rd", 32'(_usb_rd), 32'd1);
    check("rst_flag_do", 32'(_flag_do), 32'd0);
    check("rst_flag_di", 32'(_flag_di), 32'd1);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_oe", 32'(usb_d_oe), 32'd0);
    repeat (3) @(negedge clk);

    // 2: two bytes out, second one gated by _txe high then low
    cpu_write(8'h41);
    cpu_write(8'h42);
    wait_got(1, 40);
    _txe = 1'b1;
    ok = 1'b1;
    repeat (8) begin @(negedge clk); if (usb_wr) ok = 1'b0; end
    check("txe_gate", 32'(ok), 32'd1);
    _txe = 1'b0;
    n = 0;
    while (!usb_wr && n < 10) begin @(negedge clk); n++; end
    check("wr_restart_latency", n, 3);
    wait_got(2, 40);
    repeat (30) @(negedge clk);
    check("t2_count", got_q.size(), 2);
    check("t2_byte0", 32'(got_q[0]), 32'h41);
    check("t2_byte1", 32'(got_q[1]), 32'h42);

    // 3: fill TX with _txe high, overrun on the fifth, drain exactly four
    _txe = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) cpu_write(8'h10 + 8'(i));
    check("t3_full", 32'(_flag_do), 32'd1);
    check("t3_no_ovr", 32'(overrun), 32'd0);
    cpu_write(8'h14);
    check("t3_ovr", 32'(overrun), 32'd1);
    check("t3_still_full", 32'(_flag_do), 32'd1);
    base = got_q.size();
    _txe = 1'b0;
    wait_got(base + 4, 200);
    repeat (40) @(negedge clk);
    check("t3_count", got_q.size(), base + 4);
    for (int i = 0; i < 4; i++)
      if (got_q.size() > base + i) check("t3_byte", 32'(got_q[base + i]), 32'h10 + i);
    check("t3_empty", 32'(_flag_do), 32'd0);

    // 4: single read, pop, then fill RX and confirm no further _usb_rd
    _txe = 1'b1;
    usb_d_in = 8'h5A;
    _rxf = 1'b0;
    wait_rd_done(40);
    _rxf = 1'b1;
    check("t4_flag_di", 32'(_flag_di), 32'd0);
    check("t4_data", 32'(data_out), 32'h5A);
    cpu_pop();
    check("t4_pop_flag", 32'(_flag_di), 32'd1);
    check("t4_pop_data", 32'(data_out), 32'h00);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      usb_d_in = 8'hA0 + 8'(i);
      _rxf = 1'b0;
      wait_rd_done(60);
      _rxf = 1'b1;
    end
    repeat (8) @(negedge clk);
    check("t4_full_head", 32'(data_out), 32'hA0);
    strobes0 = rd_strobes;
    _rxf = 1'b0;
    repeat (30) @(negedge clk);
    check("t4_no_rd_when_full", rd_strobes, strobes0);
    _rxf = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", 32'(data_out), 32'hA0 + i);
      cpu_pop();
    end
    check("t4_empty", 32'(_flag_di), 32'd1);

    // 5: read and write become ready together, read goes first
    cpu_write(8'h77);
    repeat (2) @(negedge clk);
    usb_d_in = 8'hC3;
    base = got_q.size();
    _rxf = 1'b0; _txe = 1'b0;
    seen = 1'b0; rd_first = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (usb_wr || !_usb_rd) begin seen = 1'b1; rd_first = !_usb_rd; end
    end
    if (!seen) timeout("t5_first_strobe");
    else check("t5_rx_priority", 32'(rd_first), 32'd1);
    wait_rd_done(40);
    _rxf = 1'b1;
    check("t5_rx_data", 32'(data_out), 32'hC3);
    wait_got(base + 1, 60);
    if (got_q.size() > base) check("t5_tx_byte", 32'(got_q[base]), 32'h77);
    cpu_pop();
    repeat (25) @(negedge clk);

    // 6: reset in the middle of a write strobe
    usb_d_in = 8'h99;
    _rxf = 1'b0;
    wait_rd_done(60);
    _rxf = 1'b1;
    _txe = 1'b1;
    repeat (4) @(negedge clk);
    cpu_write(8'h55);
    cpu_write(8'h56);
    check("t6_pre_ovr", 32'(overrun), 32'd1);
    check("t6_pre_di", 32'(_flag_di), 32'd0);
    base = got_q.size();
    _txe = 1'b0;
    n = 0;
    while (!usb_wr && n < 20) begin @(negedge clk); n++; end
    if (!usb_wr) timeout("t6_wr_start");
    @(negedge clk);
    _mr = 1'b0;
    #1;
    check("t6_wr_async", 32'(usb_wr), 32'd0);
    check("t6_oe", 32'(usb_d_oe), 32'd0);
    check("t6_dout", 32'(usb_d_out), 32'h00);
    check("t6_ovr", 32'(overrun), 32'd0);
    check("t6_flag_do", 32'(_flag_do), 32'd0);
    check("t6_flag_di", 32'(_flag_di), 32'd1);
    check("t6_data_out", 32'(data_out), 32'h00);
    @(negedge clk);
    _mr = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_abandoned", got_q.size(), base);
    cpu_write(8'h66);
    wait_got(base + 1, 40);
    repeat (25) @(negedge clk);
    check("t6_count", got_q.size(), base + 1);
    if (got_q.size() > base) check("t6_resume_byte", 32'(got_q[base]), 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
